// File: rtl/usb_trigger_pkg.sv
// Shared definitions for the USB trigger pulse generator.
// Contents: default counter widths and the controller state encoding.
// Build option: USB_TRIGGER_QUEUE_EN (see usb_trigger_pulse_gen.sv).
package usb_trigger_pkg;

    localparam int unsigned DefDelayBits = 20;
    localparam int unsigned DefWidthBits = 17;
    localparam int unsigned DefMissBits  = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDelay = 2'd1,
        StPulse = 2'd2
    } state_e;

endpackage

// File: rtl/usb_trigger_pulse_gen_if.sv
// Bus between the pattern-matcher side and the trigger pulse generator.
// master: drives arm/match/delay/width, observes trigger/busy/missed.
// slave : the pulse generator itself.
// Signals:
//   I_arm            level, matches accepted only while high
//   I_match_trigger  one-cycle match pulse
//   I_delay          match-to-trigger delay in fe_clk cycles
//   I_width          trigger high time in cycles (0 behaves as 1)
//   O_trigger        registered trigger pulse
//   O_busy           high whenever the generator is not idle
//   O_missed         saturating count of dropped matches
interface usb_trigger_pulse_gen_if
    import usb_trigger_pkg::*;
#(
    parameter int unsigned pDELAY_BITS = DefDelayBits,
    parameter int unsigned pWIDTH_BITS = DefWidthBits,
    parameter int unsigned pMISS_BITS  = DefMissBits
);
    logic                   I_arm;
    logic                   I_match_trigger;
    logic [pDELAY_BITS-1:0] I_delay;
    logic [pWIDTH_BITS-1:0] I_width;
    logic                   O_trigger;
    logic                   O_busy;
    logic [pMISS_BITS-1:0]  O_missed;

    modport master (
        output I_arm, I_match_trigger, I_delay, I_width,
        input  O_trigger, O_busy, O_missed
    );

    modport slave (
        input  I_arm, I_match_trigger, I_delay, I_width,
        output O_trigger, O_busy, O_missed
    );
endinterface

// File: rtl/usb_trigger_downcnt.sv
// Loadable down-counter that stops at zero.
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset
//   load_i      load load_val_i (has priority over en_i)
//   load_val_i  value to load
//   en_i        decrement by one when non-zero
//   zero_o      count is zero
module usb_trigger_downcnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);
    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/usb_trigger_pulse_gen.sv
// Delayed, programmable-width trigger pulse generator fed by the USB pattern matcher.
// A match accepted at an edge while idle and armed latches the delay and width; the
// trigger rises D edges later and stays high max(width,1) cycles. Matches arriving
// while busy are dropped and counted in a saturating counter that clears on reset
// or on a rising edge of the arm input.
// Ports:
//   fe_clk   sole clock
//   reset_i  synchronous active-low reset
//   bus      usb_trigger_pulse_gen_if.slave (arm, match, delay, width, trigger,
//            busy, missed)
// Build option: define USB_TRIGGER_QUEUE_EN to hold one pending match while busy and
// replay it straight after the current pulse.
module usb_trigger_pulse_gen
    import usb_trigger_pkg::*;
#(
    parameter int unsigned pDELAY_BITS = DefDelayBits,
    parameter int unsigned pWIDTH_BITS = DefWidthBits,
    parameter int unsigned pMISS_BITS  = DefMissBits
) (
    input  logic                    fe_clk,
    input  logic                    reset_i,
    usb_trigger_pulse_gen_if.slave  bus
);
    state_e                state_q, state_d;
    logic                  arm_q;
    logic                  trig_q, trig_d;
    logic [pMISS_BITS-1:0] missed_q, missed_d;
    logic                  start;
    logic                  miss_inc;
    logic                  accept;
    logic                  dly_zero, wid_zero;
`ifdef USB_TRIGGER_QUEUE_EN
    logic                  pend_q, pend_d;
`endif

    // Counters hold "cycles remaining minus one" so the zero flag marks the last cycle.
    logic [pDELAY_BITS-1:0] dly_load_val;
    logic [pWIDTH_BITS-1:0] wid_load_val;
    assign dly_load_val = bus.I_delay - 1'b1;
    assign wid_load_val = (bus.I_width == '0) ? '0 : bus.I_width - 1'b1;

    assign accept = bus.I_arm & bus.I_match_trigger;

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        miss_inc = 1'b0;
`ifdef USB_TRIGGER_QUEUE_EN
        pend_d   = pend_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) start = 1'b1;
            end
            StDelay: begin
                if (!bus.I_arm) begin
                    state_d = StIdle;
                end else if (dly_zero) begin
                    state_d = StPulse;
                end
            end
            StPulse: begin
                if (wid_zero) begin
                    state_d = StIdle;
`ifdef USB_TRIGGER_QUEUE_EN
                    // A match in this last cycle is queued and replayed at once.
                    if (bus.I_arm && (pend_q || bus.I_match_trigger)) start = 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_q != StIdle) && accept) begin
`ifdef USB_TRIGGER_QUEUE_EN
            if (pend_q) miss_inc = 1'b1;
            else        pend_d   = 1'b1;
`else
            miss_inc = 1'b1;
`endif
        end

`ifdef USB_TRIGGER_QUEUE_EN
        if (start || !bus.I_arm) pend_d = 1'b0;
`endif

        // Zero delay skips the DELAY state so the trigger rises on the accepting edge.
        if (start) state_d = (bus.I_delay == '0) ? StPulse : StDelay;

        missed_d = missed_q;
        if (bus.I_arm && !arm_q) begin
            missed_d = '0;
        end else if (miss_inc && !(&missed_q)) begin
            missed_d = missed_q + 1'b1;
        end

        trig_d = (state_d == StPulse);
    end

    always_ff @(posedge fe_clk) begin
        if (!reset_i) begin
            state_q  <= StIdle;
            arm_q    <= 1'b0;
            trig_q   <= 1'b0;
            missed_q <= '0;
        end else begin
            state_q  <= state_d;
            arm_q    <= bus.I_arm;
            trig_q   <= trig_d;
            missed_q <= missed_d;
        end
    end

`ifdef USB_TRIGGER_QUEUE_EN
    always_ff @(posedge fe_clk) begin
        if (!reset_i) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    usb_trigger_downcnt #(
        .Width (pDELAY_BITS)
    ) u_delay_cnt (
        .clk_i      (fe_clk),
        .rst_ni     (reset_i),
        .load_i     (start),
        .load_val_i (dly_load_val),
        .en_i       (state_q == StDelay),
        .zero_o     (dly_zero)
    );

    usb_trigger_downcnt #(
        .Width (pWIDTH_BITS)
    ) u_width_cnt (
        .clk_i      (fe_clk),
        .rst_ni     (reset_i),
        .load_i     (start),
        .load_val_i (wid_load_val),
        .en_i       (state_q == StPulse),
        .zero_o     (wid_zero)
    );

    assign bus.O_trigger = trig_q;
    assign bus.O_busy    = (state_q != StIdle);
    assign bus.O_missed  = missed_q;
endmodule

// File: tb/tb_usb_trigger_pulse_gen.sv
// Self-checking bench for usb_trigger_pulse_gen: table of delay/width cases, directed
// corner sequences, then randomized traffic against an interval-based reference model.
module tb_usb_trigger_pulse_gen;

    logic fe_clk = 1'b0;
    logic reset_i;

    usb_trigger_pulse_gen_if bus ();

    usb_trigger_pulse_gen dut (
        .fe_clk  (fe_clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 fe_clk = ~fe_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the event in flight is an interval of edges.
    // acc = accepting edge, rise = acc + D, last = rise + max(W,1) - 1.
    longint t = 0;
    bit     ev_active = 0;
    longint ev_acc, ev_rise, ev_last;
    bit     m_pend = 0;
    int     m_missed = 0;
    bit     m_arm_prev = 0;
    bit     e_trig, e_busy;

    // 0 idle, 1 delay, 2 pulse (state after edge x)
    function automatic int st(input longint x);
        if (!ev_active || x < ev_acc || x > ev_last) return 0;
        if (x < ev_rise) return 1;
        return 2;
    endfunction

    task automatic model_step(input bit rst_n, input bit arm, input bit match,
                              input longint d, input longint w);
        int  s;
        bit  ending, start, inc;
        t++;
        if (!rst_n) begin
            ev_active = 0; m_pend = 0; m_missed = 0; m_arm_prev = 0;
            e_trig = 0; e_busy = 0;
            return;
        end
        s      = st(t - 1);
        ending = (s == 2) && (t - 1 == ev_last);
        start  = 0;
        inc    = 0;
        if (s == 1 && !arm) ev_active = 0;
        if (arm && match) begin
            if (s == 0) start = 1;
            else begin
`ifdef USB_TRIGGER_QUEUE_EN
                if (m_pend) inc = 1; else m_pend = 1;
`else
                inc = 1;
`endif
            end
        end
        if (!arm) m_pend = 0;
`ifdef USB_TRIGGER_QUEUE_EN
        if (ending && m_pend && arm) begin
            start  = 1;
            m_pend = 0;
        end
`endif
        if (start) begin
            ev_active = 1;
            ev_acc    = t;
            ev_rise   = t + d;
            ev_last   = ev_rise + ((w == 0) ? 1 : w) - 1;
        end
        if (arm && !m_arm_prev) m_missed = 0;
        else if (inc && m_missed < 255) m_missed++;
        m_arm_prev = arm;
        e_trig = (st(t) == 2);
        e_busy = (st(t) != 0);
    endtask

    // Inputs are driven 1 time unit after an edge; outputs sampled 1 unit after the next.
    task automatic tick();
        model_step(reset_i, bus.I_arm, bus.I_match_trigger, bus.I_delay, bus.I_width);
        @(posedge fe_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        bus.I_arm = 1'b0;
        bus.I_match_trigger = 1'b0;
        tick();
        tick();
        reset_i = 1'b1;
    endtask

    typedef struct {
        int unsigned d;
        int unsigned w;
        int          rise;
        int          len;
        int          busy;
    } vec_t;

    vec_t vecs[7];

    int rise, len, nbusy, npulse;
    bit prev;

    initial begin
        vecs[0] = '{d: 5, w: 3,  rise: 6, len: 3,  busy: 8};
        vecs[1] = '{d: 0, w: 0,  rise: 1, len: 1,  busy: 1};
        vecs[2] = '{d: 1, w: 1,  rise: 2, len: 1,  busy: 2};
        vecs[3] = '{d: 2, w: 4,  rise: 3, len: 4,  busy: 6};
        vecs[4] = '{d: 7, w: 0,  rise: 8, len: 1,  busy: 8};
        vecs[5] = '{d: 3, w: 10, rise: 4, len: 10, busy: 13};
        vecs[6] = '{d: 0, w: 5,  rise: 1, len: 5,  busy: 5};

        reset_i = 1'b0;
        bus.I_arm = 1'b0;
        bus.I_match_trigger = 1'b0;
        bus.I_delay = '0;
        bus.I_width = '0;
        #1;
        do_reset();
        chk("reset_trig", bus.O_trigger, 0);
        chk("reset_busy", bus.O_busy, 0);
        chk("reset_missed", bus.O_missed, 0);

        // Table: match at cycle 0, observe edges 1..40.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            bus.I_arm = 1'b1;
            tick();
            bus.I_delay = 20'(vecs[i].d);
            bus.I_width = 17'(vecs[i].w);
            bus.I_match_trigger = 1'b1;
            rise = -1; len = 0; nbusy = 0;
            for (int k = 1; k <= 40; k++) begin
                tick();
                bus.I_match_trigger = 1'b0;
                if (bus.O_trigger) begin
                    if (rise < 0) rise = k;
                    len++;
                end
                if (bus.O_busy) nbusy++;
            end
            chk($sformatf("vec%0d_rise", i), rise, vecs[i].rise);
            chk($sformatf("vec%0d_len", i), len, vecs[i].len);
            chk($sformatf("vec%0d_busy", i), nbusy, vecs[i].busy);
        end

        // Reset during PULSE aborts at once.
        do_reset();
        bus.I_arm = 1'b1;
        tick();
        bus.I_delay = 20'd2; bus.I_width = 17'd10; bus.I_match_trigger = 1'b1;
        tick();
        bus.I_match_trigger = 1'b0;
        tick(); tick(); tick();
        chk("midrst_pulse_on", bus.O_trigger, 1);
        reset_i = 1'b0;
        tick();
        chk("midrst_trig", bus.O_trigger, 0);
        chk("midrst_busy", bus.O_busy, 0);
        chk("midrst_missed", bus.O_missed, 0);
        reset_i = 1'b1;

        // Drops while busy.
        do_reset();
        bus.I_arm = 1'b1;
        tick();
        bus.I_delay = 20'd100; bus.I_width = 17'd2;
        npulse = 0; prev = 0;
        for (int k = 0; k < 240; k++) begin
            bus.I_match_trigger = (k == 0 || k == 10 || k == 20);
            tick();
            if (bus.O_trigger && !prev) npulse++;
            prev = bus.O_trigger;
        end
        bus.I_match_trigger = 1'b0;
`ifdef USB_TRIGGER_QUEUE_EN
        chk("drop_pulses", npulse, 2);
        chk("drop_missed", bus.O_missed, 1);
`else
        chk("drop_pulses", npulse, 1);
        chk("drop_missed", bus.O_missed, 2);
`endif

        // Disarm during DELAY: no pulse, idle next edge.
        do_reset();
        bus.I_arm = 1'b1;
        tick();
        bus.I_delay = 20'd10; bus.I_width = 17'd2; bus.I_match_trigger = 1'b1;
        tick();
        bus.I_match_trigger = 1'b0;
        tick(); tick(); tick();
        bus.I_arm = 1'b0;
        tick();
        chk("disarm_delay_busy", bus.O_busy, 0);
        len = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.O_trigger) len++;
        end
        chk("disarm_delay_nopulse", len, 0);

        // Disarm during PULSE: full width.
        do_reset();
        bus.I_arm = 1'b1;
        tick();
        bus.I_delay = 20'd1; bus.I_width = 17'd10; bus.I_match_trigger = 1'b1;
        tick();
        bus.I_match_trigger = 1'b0;
        tick();
        chk("disarm_pulse_on", bus.O_trigger, 1);
        bus.I_arm = 1'b0;
        len = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.O_trigger) len++;
        end
        chk("disarm_pulse_len", len, 10);

        // Live reprogram during DELAY does not move the event.
        do_reset();
        bus.I_arm = 1'b1;
        tick();
        bus.I_delay = 20'd5; bus.I_width = 17'd3; bus.I_match_trigger = 1'b1;
        tick();
        bus.I_match_trigger = 1'b0;
        bus.I_delay = 20'd50; bus.I_width = 17'd1;
        rise = -1; len = 0;
        for (int k = 2; k <= 40; k++) begin
            tick();
            if (bus.O_trigger) begin
                if (rise < 0) rise = k;
                len++;
            end
        end
        chk("reprog_rise", rise, 6);
        chk("reprog_len", len, 3);

        // Saturation and clear on re-arm.
        do_reset();
        bus.I_arm = 1'b1;
        tick();
        bus.I_delay = 20'd400; bus.I_width = 17'd1; bus.I_match_trigger = 1'b1;
        for (int k = 0; k < 301; k++) tick();
        bus.I_match_trigger = 1'b0;
        chk("sat_missed", bus.O_missed, 255);
        bus.I_arm = 1'b0;
        tick();
        chk("sat_hold_disarmed", bus.O_missed, 255);
        bus.I_arm = 1'b1;
        tick();
        chk("sat_rearm_clear", bus.O_missed, 0);

        // Randomized traffic against the model.
        do_reset();
        bus.I_arm = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            reset_i = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 39) == 0) bus.I_arm = ~bus.I_arm;
            bus.I_match_trigger = ($urandom_range(0, 9) < 3);
            bus.I_delay = 20'($urandom_range(0, 8));
            bus.I_width = 17'($urandom_range(0, 5));
            tick();
            chk("rnd_trig", bus.O_trigger, e_trig);
            chk("rnd_busy", bus.O_busy, e_busy);
            chk("rnd_missed", bus.O_missed, m_missed);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
